digit_serial_adder: RTL and testbench

//   Parametrised multi-cycle adder/subtractor. Adds or subtracts two WIDTH-bit operands,

---
 rtl/adder_pkg.sv | 32 +++
 rtl/digit_adder.sv | 26 ++
 rtl/digit_serial_adder.sv | 143 ++++++++++++++
 tb/tb_digit_serial_adder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder: FSM encoding, counter sizing
// and an elaboration-time guard on the WIDTH/DIGIT combination.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Expands to a generate-if that stops elaboration on an unusable geometry.
`define ADDER_PARAM_CHECK(W, D) \
    if (((W) < 2) || ((D) < 1) || ((D) > (W)) || (((W) % (D)) != 0)) begin : g_param_error \
        $error("digit_serial_adder: WIDTH must be >= 2 and DIGIT must divide WIDTH"); \
    end

package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a single-digit counter still has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`endif

// File: rtl/digit_adder.sv
// Combinational ripple of DIGIT full adders; also exposes the carry into the top bit
// so the caller can form the two's-complement overflow flag.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = c_in;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
        assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign c_out    = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock, LSB digit first,
// with valid/ready handshakes on both the operand and result sides.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            NDIG = WIDTH / DIGIT;
    localparam int            CW   = clog2(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    `ADDER_PARAM_CHECK(WIDTH, DIGIT)

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_cmsb;
    logic [WIDTH-1:0] sum_shift;
    logic             accept;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a        (a_q[DIGIT-1:0]),
        .b        (b_q[DIGIT-1:0]),
        .c_in     (carry_q),
        .s        (dig_s),
        .c_out    (dig_cout),
        .c_msb_in (dig_cmsb)
    );

    // Each new digit enters at the MSB end, so after NDIG steps the result is aligned.
    if (DIGIT == WIDTH) begin : g_single_digit
        assign sum_shift = dig_s;
    end else begin : g_multi_digit
        assign sum_shift = {dig_s, sum_q[WIDTH-1:DIGIT]};
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)         state_d = RUN;
            RUN:     if (cnt_q == LAST)  state_d = DONE;
            DONE:    if (out_ready)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Subtraction is a + ~b + 1; cin is ignored in that mode.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_shift;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d = dig_cout;
                    ovf_d  = dig_cmsb ^ dig_cout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: an 8-bit/2-bit instance for the main scenarios
// and a 16-bit single-digit instance for the one-cycle case.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic       in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic       out_valid, out_ready = 1'b0, cout, ovf;
    logic [7:0] a = '0, b = '0, sum;

    logic        w_in_valid = 1'b0, w_in_ready, w_cin = 1'b0, w_sub = 1'b0;
    logic        w_out_valid, w_out_ready = 1'b0, w_cout, w_ovf;
    logic [15:0] w_a = '0, w_b = '0, w_sum;

    int n_cmp = 0;
    int n_bad = 0;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
    );

    // Drives one operation through the narrow instance and reports what it produced.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic ts, output logic [7:0] rs, output logic rc,
                          output logic ro, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        rs = sum; rc = cout; ro = ovf;
        $display("op a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                 ta, tb_v, tc, ts, rs, rc, ro, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, cout, ovf} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags: got rdy/vld/cout/ovf=%b want 1000",
                     {in_ready, out_valid, cout, ovf});
        end
        n_cmp++;
        if (sum !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_sum: got %h want 00", sum);
        end
        n_cmp++;
        if ({w_in_ready, w_out_valid, w_cout, w_ovf} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_wide_flags: got %b want 1000",
                     {w_in_ready, w_out_valid, w_cout, w_ovf});
        end
        n_cmp++;
        if (w_sum !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_wide_sum: got %h want 0000", w_sum);
        end
        $display("reset checked");
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        logic [7:0] va [0:4] = '{8'h5A, 8'hFF, 8'h00, 8'h10, 8'h80};
        logic [7:0] vb [0:4] = '{8'h3C, 8'h01, 8'h00, 8'h20, 8'h01};
        logic       vc [0:4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       vm [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] es [0:4] = '{8'h96, 8'h00, 8'h01, 8'hF0, 8'h7F};
        logic       ec [0:4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       eo [0:4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] rs;
        logic       rc, ro;
        int         lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], vm[i], rs, rc, ro, lat);
            n_cmp++;
            if (rs !== es[i]) begin
                n_bad++;
                $display("FAIL op%0d_sum: got %h want %h", i, rs, es[i]);
            end
            n_cmp++;
            if (rc !== ec[i]) begin
                n_bad++;
                $display("FAIL op%0d_cout: got %b want %b", i, rc, ec[i]);
            end
            n_cmp++;
            if (ro !== eo[i]) begin
                n_bad++;
                $display("FAIL op%0d_ovf: got %b want %b", i, ro, eo[i]);
            end
            n_cmp++;
            if (lat !== 4) begin
                n_bad++;
                $display("FAIL op%0d_latency: got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL bp_latency: got %0d want 4", lat);
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h46}) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got vld/rdy/cout/ovf/sum=%b%b%b%b/%h want 1000/46",
                         k, out_valid, in_ready, cout, ovf, sum);
            end
        end
        $display("held 5 cycles sum=%h", sum);
        // in_valid stays high across the handshake edge; that operand must be ignored.
        in_valid = 1'b1; a = 8'hAA; b = 8'hBB; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        a = 8'h01; b = 8'h02;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_after_handshake: got rdy/vld=%b want 10", {in_ready, out_valid});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        n_cmp++;
        if (lat !== 4 || sum !== 8'h03) begin
            n_bad++;
            $display("FAIL bp_next_op: got sum=%h lat=%0d want sum=03 lat=4", sum, lat);
        end
        $display("back-to-back op sum=%h lat=%0d", sum, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] rs;
        logic       rc, ro;
        int         lat;
        @(negedge clk);
        a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, cout, ovf, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL midrun_reset: got vld/rdy/cout/ovf/sum=%b%b%b%b/%h want 0100/00",
                     out_valid, in_ready, cout, ovf, sum);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL midrun_reset_hold: got vld/rdy=%b want 01", {out_valid, in_ready});
        end
        rst_n = 1'b1;
        $display("reset during RUN applied");
        run_op(8'h01, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat);
        n_cmp++;
        if (rs !== 8'h02 || rc !== 1'b0 || ro !== 1'b0 || lat !== 4) begin
            n_bad++;
            $display("FAIL post_reset_op: got sum=%h cout=%b ovf=%b lat=%0d want 02 0 0 4",
                     rs, rc, ro, lat);
        end
    endtask

    task automatic test_wide_single_digit();
        int lat;
        @(negedge clk);
        w_a = 16'h7FFF; w_b = 16'h0001; w_cin = 1'b0; w_sub = 1'b0; w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0; w_a = 16'hFFFF; w_sub = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!w_out_valid && lat < 40);
        $display("wide op 7fff+0001 -> sum=%h cout=%b ovf=%b lat=%0d", w_sum, w_cout, w_ovf, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL wide_latency: got %0d want 1", lat);
        end
        n_cmp++;
        if (w_sum !== 16'h8000) begin
            n_bad++;
            $display("FAIL wide_sum: got %h want 8000", w_sum);
        end
        n_cmp++;
        if ({w_cout, w_ovf} !== 2'b01) begin
            n_bad++;
            $display("FAIL wide_flags: got cout/ovf=%b want 01", {w_cout, w_ovf});
        end
        w_out_ready = 1'b1;
        @(posedge clk);
        #1 w_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_backpressure();
        test_reset_mid_run();
        test_wide_single_digit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
